// File: rtl/rot_ctrl.sv
// Job controller for the rotation engine: register file, size validation,
// start/abort sequencing of the set address generator and completed-set counting.
module rot_ctrl (
  input  logic        I_RC_HCLK,
  input  logic        I_RC_RESET,
  input  logic        I_RC_SEL,
  input  logic        I_RC_WR,
  input  logic [1:0]  I_RC_ADDR,
  input  logic [31:0] I_RC_WDATA,
  output logic [31:0] O_RC_RDATA,
  input  logic        I_RC_CS_WRITE,
  output logic        O_RC_CS_START,
  output logic        O_RC_CS_RESET_N,
  output logic [15:0] O_RC_HEIGHT,
  output logic [15:0] O_RC_WIDTH,
  output logic [1:0]  O_RC_DEGREES,
  output logic        O_RC_DIRECTION,
  output logic        O_RC_BUSY,
  output logic        O_RC_IRQ
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        irq_en_q, irq_en_d;
  logic [1:0]  cfg_deg_q, cfg_deg_d;
  logic        cfg_dir_q, cfg_dir_d;
  logic [15:0] size_h_q, size_h_d;
  logic [15:0] size_w_q, size_w_d;
  logic [15:0] sh_h_q, sh_h_d;
  logic [15:0] sh_w_q, sh_w_d;
  logic [1:0]  sh_deg_q, sh_deg_d;
  logic        sh_dir_q, sh_dir_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        aborted_q, aborted_d;
  logic [23:0] sets_q, sets_d;
  logic [23:0] total_q, total_d;
  logic        cs_wr_prev_q, cs_wr_prev_d;
  logic        start_q, start_d;
  logic [1:0]  rst_cnt_q, rst_cnt_d;

  logic        wr_ctrl, wr_cfg, wr_size, wr_status;
  logic        busy, start_req, abort_req, fall, size_ok;
  logic        clr_flags, hw_done, hw_err, count_en;
  logic [23:0] h_ceil, w_ceil, sets_inc;

  assign wr_ctrl   = I_RC_SEL & I_RC_WR & (I_RC_ADDR == 2'd0);
  assign wr_cfg    = I_RC_SEL & I_RC_WR & (I_RC_ADDR == 2'd1);
  assign wr_size   = I_RC_SEL & I_RC_WR & (I_RC_ADDR == 2'd2);
  assign wr_status = I_RC_SEL & I_RC_WR & (I_RC_ADDR == 2'd3);
  assign busy      = (state_q != ST_IDLE);
  // ABORT dominates START in the same write; ABORT only matters while busy.
  assign start_req = wr_ctrl & I_RC_WDATA[0] & ~I_RC_WDATA[1];
  assign abort_req = wr_ctrl & I_RC_WDATA[1] & busy;
  assign fall      = cs_wr_prev_q & ~I_RC_CS_WRITE;
  assign size_ok   = (sh_h_q != 16'd0) && (sh_w_q != 16'd0) &&
                     !sh_h_q[15] && (sh_w_q[15:14] == 2'b00);
  assign h_ceil    = ({8'd0, sh_h_q} + 24'd7) >> 3;
  assign w_ceil    = ({8'd0, sh_w_q} + 24'd7) >> 3;
  assign sets_inc  = sets_q + 24'd1;

  // Next-state and register-update logic.
  always_comb begin
    state_d      = state_q;
    sh_h_d       = sh_h_q;
    sh_w_d       = sh_w_q;
    sh_deg_d     = sh_deg_q;
    sh_dir_d     = sh_dir_q;
    total_d      = total_q;
    start_d      = 1'b0;
    clr_flags    = 1'b0;
    hw_done      = 1'b0;
    hw_err       = 1'b0;
    count_en     = 1'b0;
    cs_wr_prev_d = I_RC_CS_WRITE;
    rst_cnt_d    = (rst_cnt_q != 2'd0) ? (rst_cnt_q - 2'd1) : 2'd0;
    irq_en_d     = wr_ctrl ? I_RC_WDATA[2] : irq_en_q;
    cfg_deg_d    = (wr_cfg && !busy) ? I_RC_WDATA[1:0] : cfg_deg_q;
    cfg_dir_d    = (wr_cfg && !busy) ? I_RC_WDATA[2] : cfg_dir_q;
    size_h_d     = (wr_size && !busy) ? I_RC_WDATA[15:0] : size_h_q;
    size_w_d     = (wr_size && !busy) ? I_RC_WDATA[31:16] : size_w_q;

    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          state_d   = ST_CHECK;
          sh_h_d    = size_h_q;
          sh_w_d    = size_w_q;
          sh_deg_d  = cfg_deg_q;
          sh_dir_d  = cfg_dir_q;
          clr_flags = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (size_ok) begin
          state_d = ST_RUN;
          start_d = 1'b1;
          total_d = h_ceil * w_ceil;
        end else begin
          state_d = ST_IDLE;
          hw_err  = 1'b1;
        end
      end
      ST_RUN: begin
        if (fall) begin
          count_en = 1'b1;
          state_d  = (sets_inc == total_q) ? ST_FINISH : ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        hw_done = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides whatever the job was about to do, including a pending count.
    if (abort_req) begin
      state_d   = ST_IDLE;
      start_d   = 1'b0;
      hw_done   = 1'b0;
      hw_err    = 1'b0;
      count_en  = 1'b0;
      rst_cnt_d = 2'd2;
    end else begin
      rst_cnt_d = rst_cnt_d;
    end

    done_d    = clr_flags ? 1'b0 : ((done_q    & ~(wr_status & I_RC_WDATA[1])) | hw_done);
    err_d     = clr_flags ? 1'b0 : ((err_q     & ~(wr_status & I_RC_WDATA[2])) | hw_err);
    aborted_d = clr_flags ? 1'b0 : ((aborted_q & ~(wr_status & I_RC_WDATA[3])) | abort_req);
    sets_d    = clr_flags ? 24'd0 : (count_en ? sets_inc : sets_q);
  end

  // State and register storage with synchronous reset.
  always_ff @(posedge I_RC_HCLK) begin
    if (I_RC_RESET) begin
      state_q      <= ST_IDLE;
      irq_en_q     <= 1'b0;
      cfg_deg_q    <= 2'd0;
      cfg_dir_q    <= 1'b0;
      size_h_q     <= 16'd0;
      size_w_q     <= 16'd0;
      sh_h_q       <= 16'd0;
      sh_w_q       <= 16'd0;
      sh_deg_q     <= 2'd0;
      sh_dir_q     <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      aborted_q    <= 1'b0;
      sets_q       <= 24'd0;
      total_q      <= 24'd0;
      cs_wr_prev_q <= 1'b0;
      start_q      <= 1'b0;
      rst_cnt_q    <= 2'd0;
    end else begin
      state_q      <= state_d;
      irq_en_q     <= irq_en_d;
      cfg_deg_q    <= cfg_deg_d;
      cfg_dir_q    <= cfg_dir_d;
      size_h_q     <= size_h_d;
      size_w_q     <= size_w_d;
      sh_h_q       <= sh_h_d;
      sh_w_q       <= sh_w_d;
      sh_deg_q     <= sh_deg_d;
      sh_dir_q     <= sh_dir_d;
      done_q       <= done_d;
      err_q        <= err_d;
      aborted_q    <= aborted_d;
      sets_q       <= sets_d;
      total_q      <= total_d;
      cs_wr_prev_q <= cs_wr_prev_d;
      start_q      <= start_d;
      rst_cnt_q    <= rst_cnt_d;
    end
  end

  // Register read mux; START and ABORT always read back as zero.
  always_comb begin
    if (I_RC_SEL) begin
      case (I_RC_ADDR)
        2'd0:    O_RC_RDATA = {29'd0, irq_en_q, 2'b00};
        2'd1:    O_RC_RDATA = {29'd0, cfg_dir_q, cfg_deg_q};
        2'd2:    O_RC_RDATA = {size_w_q, size_h_q};
        2'd3:    O_RC_RDATA = {sets_q, 4'd0, aborted_q, err_q, done_q, busy};
        default: O_RC_RDATA = 32'd0;
      endcase
    end else begin
      O_RC_RDATA = 32'd0;
    end
  end

  assign O_RC_CS_START   = start_q;
  assign O_RC_CS_RESET_N = ~I_RC_RESET & (rst_cnt_q == 2'd0);
  assign O_RC_HEIGHT     = sh_h_q;
  assign O_RC_WIDTH      = sh_w_q;
  assign O_RC_DEGREES    = sh_deg_q;
  assign O_RC_DIRECTION  = sh_dir_q;
  assign O_RC_BUSY       = busy;
  assign O_RC_IRQ        = done_q & irq_en_q;

endmodule

// File: tb/tb_rot_ctrl.sv
// Directed bench for rot_ctrl: inputs change and outputs are sampled 1ns after
// each rising edge; expected values are hand-derived constants.
module tb_rot_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        wr;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        cs_write;
  logic        cs_start;
  logic        cs_reset_n;
  logic [15:0] height;
  logic [15:0] width;
  logic [1:0]  degrees;
  logic        direction;
  logic        busy;
  logic        irq;

  int total = 0;
  int bad   = 0;
  logic [31:0] rv;

  rot_ctrl dut (
    .I_RC_HCLK      (clk),
    .I_RC_RESET     (rst),
    .I_RC_SEL       (sel),
    .I_RC_WR        (wr),
    .I_RC_ADDR      (addr),
    .I_RC_WDATA     (wdata),
    .O_RC_RDATA     (rdata),
    .I_RC_CS_WRITE  (cs_write),
    .O_RC_CS_START  (cs_start),
    .O_RC_CS_RESET_N(cs_reset_n),
    .O_RC_HEIGHT    (height),
    .O_RC_WIDTH     (width),
    .O_RC_DEGREES   (degrees),
    .O_RC_DIRECTION (direction),
    .O_RC_BUSY      (busy),
    .O_RC_IRQ       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
    tick();
    sel = 1'b0; wr = 1'b0; wdata = 32'd0;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
    sel = 1'b1; wr = 1'b0; addr = a;
    #1;
    d = rdata;
    sel = 1'b0;
  endtask

  // One generator set: write phase high, then the low cycle that is the falling edge.
  task automatic phase();
    cs_write = 1'b1;
    repeat (8) tick();
    cs_write = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] bad_sizes [3];
    bad_sizes[0] = 32'h0010_8000;
    bad_sizes[1] = 32'h4000_0010;
    bad_sizes[2] = 32'h0000_0000;

    rst = 1'b1; sel = 1'b0; wr = 1'b0; addr = 2'd0; wdata = 32'd0; cs_write = 1'b0;
    #1;
    chk("rstn_held_t0", cs_reset_n, 1'b0);
    repeat (2) tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_start", cs_start, 1'b0);
    chk("rst_irq", irq, 1'b0);
    chk("rstn_held", cs_reset_n, 1'b0);
    rst = 1'b0;
    #1;
    chk("rstn_released", cs_reset_n, 1'b1);
    rd_reg(2'd3, rv); chk("rst_status", rv, 32'h0);

    // 16x16 job, 4 sets, IRQ enabled.
    wr_reg(2'd1, 32'h1);
    wr_reg(2'd2, 32'h0010_0010);
    wr_reg(2'd0, 32'h5);
    chk("a_busy_t1", busy, 1'b1);
    chk("a_start_t1", cs_start, 1'b0);
    tick();
    chk("a_start_t2", cs_start, 1'b1);
    chk("a_height", height, 16'd16);
    chk("a_width", width, 16'd16);
    chk("a_degrees", degrees, 2'd1);
    chk("a_direction", direction, 1'b0);
    tick();
    chk("a_start_t3", cs_start, 1'b0);
    repeat (4) phase();
    chk("a_busy_f1", busy, 1'b1);
    chk("a_irq_f1", irq, 1'b0);
    tick();
    chk("a_busy_f2", busy, 1'b0);
    chk("a_irq_f2", irq, 1'b1);
    rd_reg(2'd3, rv); chk("a_status", rv, 32'h0000_0402);
    wr_reg(2'd3, 32'h2);
    chk("a_irq_w1c", irq, 1'b0);
    rd_reg(2'd3, rv); chk("a_status_w1c", rv, 32'h0000_0400);

    // 10 high x 20 wide: 2*3 = 6 sets, IRQ disabled.
    wr_reg(2'd2, 32'h0014_000A);
    wr_reg(2'd0, 32'h1);
    tick(); tick();
    chk("b_height", height, 16'd10);
    chk("b_width", width, 16'd20);
    repeat (5) phase();
    tick();
    chk("b_busy_after5", busy, 1'b1);
    rd_reg(2'd3, rv); chk("b_status_after5", rv, 32'h0000_0501);
    phase();
    tick();
    chk("b_busy_after6", busy, 1'b0);
    chk("b_irq_masked", irq, 1'b0);
    rd_reg(2'd3, rv); chk("b_status_after6", rv, 32'h0000_0602);

    // Invalid sizes: no start pulse, err raised, cleared by W1C.
    for (int i = 0; i < 3; i++) begin
      wr_reg(2'd2, bad_sizes[i]);
      wr_reg(2'd0, 32'h1);
      chk("c_busy_t1", busy, 1'b1);
      tick();
      chk("c_start_t2", cs_start, 1'b0);
      chk("c_busy_t2", busy, 1'b0);
      rd_reg(2'd3, rv); chk("c_status_err", rv, 32'h0000_0004);
      wr_reg(2'd3, 32'h4);
      rd_reg(2'd3, rv); chk("c_status_clr", rv, 32'h0000_0000);
    end

    // Abort after 2 of 4 sets.
    wr_reg(2'd2, 32'h0010_0010);
    wr_reg(2'd0, 32'h1);
    tick(); tick();
    repeat (2) phase();
    wr_reg(2'd0, 32'h2);
    chk("d_rstn_a1", cs_reset_n, 1'b0);
    chk("d_busy_a1", busy, 1'b0);
    tick();
    chk("d_rstn_a2", cs_reset_n, 1'b0);
    tick();
    chk("d_rstn_a3", cs_reset_n, 1'b1);
    rd_reg(2'd3, rv); chk("d_status", rv, 32'h0000_0208);
    wr_reg(2'd0, 32'h1);
    tick();
    chk("d_restart_pulse", cs_start, 1'b1);
    repeat (4) phase();
    tick();
    rd_reg(2'd3, rv); chk("d_restart_status", rv, 32'h0000_0402);

    // START and ABORT together while idle.
    wr_reg(2'd0, 32'h3);
    chk("e_busy", busy, 1'b0);
    chk("e_rstn", cs_reset_n, 1'b1);
    tick();
    chk("e_start", cs_start, 1'b0);
    rd_reg(2'd3, rv); chk("e_status", rv, 32'h0000_0402);

    // CFG/SIZE writes during RUN are ignored.
    wr_reg(2'd1, 32'h3);
    wr_reg(2'd2, 32'h0008_0008);
    wr_reg(2'd0, 32'h1);
    tick(); tick();
    wr_reg(2'd1, 32'h4);
    wr_reg(2'd2, 32'h0020_0030);
    chk("f_degrees", degrees, 2'd3);
    chk("f_direction", direction, 1'b0);
    chk("f_height", height, 16'd8);
    chk("f_width", width, 16'd8);
    rd_reg(2'd1, rv); chk("f_cfg_reg", rv, 32'h3);
    rd_reg(2'd2, rv); chk("f_size_reg", rv, 32'h0008_0008);
    rd_reg(2'd3, rv); chk("f_status_run", rv, 32'h0000_0001);

    // Synchronous reset in RUN.
    rst = 1'b1;
    #1;
    chk("g_rstn_comb", cs_reset_n, 1'b0);
    tick();
    chk("g_busy", busy, 1'b0);
    chk("g_start", cs_start, 1'b0);
    chk("g_irq", irq, 1'b0);
    chk("g_height", height, 16'd0);
    chk("g_width", width, 16'd0);
    chk("g_degrees", degrees, 2'd0);
    chk("g_direction", direction, 1'b0);
    chk("g_rstn_held", cs_reset_n, 1'b0);
    rst = 1'b0;
    #1;
    chk("g_rstn_rel", cs_reset_n, 1'b1);
    rd_reg(2'd3, rv); chk("g_status", rv, 32'h0);
    rd_reg(2'd1, rv); chk("g_cfg", rv, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rot_ctrl.md
# rot_ctrl

Job controller for the rotation engine. Holds the software-visible configuration and status registers, validates the image size, and pulses start to the set address generator. It counts completed 8x8 pixel sets by watching the generator's write-phase flag, and raises done/error/interrupt. It sits between the register bus and the set address generator, and it can force the generator back to idle on abort.

## Interface
Parameters:
- none (all widths fixed)

Ports:
- I_RC_HCLK  in  1  system clock; all logic on rising edge
- I_RC_RESET  in  1  reset, synchronous, active-high
- I_RC_SEL  in  1  register access strobe (one cycle per access)
- I_RC_WR  in  1  1 = write, 0 = read (valid with I_RC_SEL)
- I_RC_ADDR  in  2  word offset: 0 CTRL, 1 CFG, 2 SIZE, 3 STATUS
- I_RC_WDATA  in  32  write data
- O_RC_RDATA  out  32  read data, combinational from I_RC_ADDR, zero when I_RC_SEL=0
- I_RC_CS_WRITE  in  1  generator write-phase flag (high during 64-cycle write phase of a set)
- O_RC_CS_START  out  1  one-cycle start pulse to generator
- O_RC_CS_RESET_N  out  1  active-low generator reset
- O_RC_HEIGHT  out  16  latched image height
- O_RC_WIDTH  out  16  latched image width
- O_RC_DEGREES  out  2  latched rotation (0/90/180/270)
- O_RC_DIRECTION  out  1  latched direction
- O_RC_BUSY  out  1  job in progress
- O_RC_IRQ  out  1  level interrupt = done & IRQ_EN

## Operation
- Registers:
  - CTRL: bit0 START (write-1, self-clearing, reads 0); bit1 ABORT (write-1, self-clearing); bit2 IRQ_EN (r/w).
  - CFG: [1:0] degrees, [2] direction.
  - SIZE: [15:0] height, [31:16] width.
  - STATUS: bit0 busy; bit1 done (W1C); bit2 err (W1C); bit3 aborted (W1C); [31:8] sets completed (24-bit).
- Writes to CFG and SIZE are ignored while busy. O_RC_HEIGHT/WIDTH/DEGREES/DIRECTION are driven from shadow copies loaded on START acceptance and stay stable for the whole job.
- FSM states: IDLE, CHECK, RUN, FINISH.
  - IDLE + START write -> CHECK. Shadows load. Done, err, aborted and the set count clear.
  - CHECK, invalid size -> IDLE with err=1. Invalid means height=0, width=0, height[15]=1, or width[15:14]!=0. No start pulse is issued.
  - CHECK, valid -> RUN. O_RC_CS_START=1 for exactly this one transition cycle. total_sets = ceil(h/8)*ceil(w/8) is computed as a 24-bit value, with ceil(x/8) = (x+7)>>3.
  - RUN: a falling edge of I_RC_CS_WRITE (registered previous value 1, current 0) increments the set count.
  - RUN: when the incremented count equals total_sets, go to FINISH.
  - FINISH -> IDLE next cycle with done=1.
- O_RC_BUSY = 1 in CHECK, RUN and FINISH.
- ABORT in CHECK/RUN/FINISH:
  - Go to IDLE next cycle; aborted=1; done not set.
  - O_RC_CS_RESET_N = 0 for exactly 2 cycles starting the cycle after the ABORT write.
  - ABORT in IDLE has no effect.
- O_RC_CS_RESET_N = 0 whenever I_RC_RESET=1.
- Simultaneous events:
  - START and ABORT in the same write: ABORT wins, START is ignored.
  - START while busy is ignored.
  - A W1C clear and a hardware set of the same bit in the same cycle: set wins.
  - A write-phase falling edge in the same cycle as ABORT is not counted.

## Timing
- Reset: state IDLE; all registers, shadows and counts are 0. O_RC_CS_START=0, O_RC_BUSY=0, O_RC_IRQ=0, O_RC_CS_RESET_N=0 while reset is held, then 1.
- START written in cycle T: CHECK in T+1; O_RC_CS_START high in T+1 (registered pulse, visible in T+2) only if valid; BUSY high from T+1.
- Invalid size: err=1 and BUSY=0 from T+2.
- Last falling edge seen in cycle F (I_RC_CS_WRITE low in F): FINISH in F+1, IDLE with done=1, BUSY=0, IRQ (if enabled) in F+2.
- Register reads return state as of the current cycle. A write takes effect the next cycle.
- Reset asserted mid-job returns everything to reset values on the next edge. No done, no IRQ.

## Test plan
- Valid 16x16 (SIZE=0x0010_0010), CFG=1, IRQ_EN=1, START -> one O_RC_CS_START pulse, 4 write-phase pulses counted, then done=1, IRQ=1, STATUS[31:8]=4, BUSY=0 two cycles after the 4th falling edge.
- Non-multiple 10x20 -> total_sets=2*3=6; done only after the 6th falling edge, not the 5th.
- Invalid sizes: height=0x8000 or width=0x4000 or 0 -> no start pulse, err=1, BUSY=0 at T+2. Write 1 to STATUS bit2 -> err=0.
- ABORT during RUN after 2 sets -> O_RC_CS_RESET_N low exactly 2 cycles, aborted=1, done=0, count=2. A subsequent START runs normally.
- START and ABORT in the same CTRL write while idle -> no start pulse. CFG/SIZE writes during RUN leave O_RC_* outputs unchanged.
- Synchronous reset asserted in RUN -> all outputs at reset values after one edge, with O_RC_CS_RESET_N low while reset is held.
